// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared CPU constants: state encoding, opcodes, instruction fields
package instr_fetch_ctrl_pkg;

  localparam int INSTR_W     = 16;
  localparam int OPCODE_W    = 4;
  localparam int REG_FIELD_W = 12;
  localparam int REG_ADDR_W  = 4;

  // Instruction word layout {opcode, rd1, rd2, wr}
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD1_MSB = 11;
  localparam int RD1_LSB = 8;
  localparam int RD2_MSB = 7;
  localparam int RD2_LSB = 4;
  localparam int WR_MSB  = 3;
  localparam int WR_LSB  = 0;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_PAUSE,
    ST_HALT
  } state_t;

  // Register 0 is never a write target, so wr == 0 suppresses the strobe as well as NOP.
  function automatic logic writes_reg(input logic [OPCODE_W-1:0]   op,
                                      input logic [OPCODE_W-1:0]   nop_op,
                                      input logic [REG_ADDR_W-1:0] wr);
    return (op != nop_op) && (wr != '0);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction sequencer: PC, instruction register and fetch/decode/execute FSM
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int                  ADDR_W  = 8,
  parameter logic [OPCODE_W-1:0] NOP_OP  = OP_NOP,
  parameter logic [OPCODE_W-1:0] HALT_OP = OP_HALT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  output logic [REG_FIELD_W-1:0] instruction,
  output logic [OPCODE_W-1:0]    opcode,
  output logic                   reg_write,
  output logic                   busy,
  output logic                   done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [OPCODE_W-1:0] ir_op;
  logic [REG_ADDR_W-1:0] ir_wr;

  assign ir_op = ir_q[OP_MSB:OP_LSB];
  assign ir_wr = ir_q[WR_MSB:WR_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      // Synchronous memory: data for the FETCH address is valid during DECODE.
      ST_DECODE: begin
        ir_d    = imem_data;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: state_d = (ir_op == HALT_OP) ? ST_HALT : ST_WRITEBACK;
      ST_WRITEBACK: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = step_mode ? ST_PAUSE : ST_FETCH;
      end
      ST_PAUSE: begin
        if (step) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign opcode      = ir_op;
  assign instruction = {ir_q[RD1_MSB:RD1_LSB], ir_q[RD2_MSB:RD2_LSB], ir_q[WR_MSB:WR_LSB]};
  assign reg_write   = (state_q == ST_WRITEBACK) && writes_reg(ir_op, NOP_OP, ir_wr);
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK) ||
                       (state_q == ST_PAUSE);
  assign done        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - self-checking bench for instr_fetch_ctrl against a program-level model
module tb_instr_fetch_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          step_mode;
  logic          step;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [11:0]   instruction;
  logic [3:0]    opcode;
  logic          reg_write;
  logic          busy;
  logic          done;

  logic [15:0]   mem [DEPTH];
  int            n_checks = 0;
  int            n_errors = 0;

  instr_fetch_ctrl #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instruction (instruction),
    .opcode      (opcode),
    .reg_write   (reg_write),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  // Program-level model: each instruction occupies 4 cycles, writeback on the 4th,
  // a HALT word is recognised on its 3rd cycle and leaves the PC on its own address.
  task automatic run_prog(input int max_instr, input int mid_start, output bit halted);
    int          exp_cyc[$];
    logic [15:0] exp_w[$];
    int          fa[$];
    int          obs_cyc[$];
    logic [15:0] obs_w[$];
    int          pc;
    int          halt_k;
    int          budget;
    logic [15:0] w;
    pc     = 0;
    halt_k = -1;
    for (int k = 0; k < max_instr; k++) begin
      fa.push_back(pc);
      w = mem[pc];
      if (w[15:12] == 4'hF) begin
        halt_k = k;
        break;
      end
      if (w[15:12] != 4'h0 && w[3:0] != 4'h0) begin
        exp_cyc.push_back(4 + 4 * k);
        exp_w.push_back(w);
      end
      pc = (pc + 1) % DEPTH;
    end
    budget = (halt_k >= 0) ? 4 * halt_k + 4 : 4 * max_instr;

    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == mid_start);
      if (reg_write) begin
        obs_cyc.push_back(c);
        obs_w.push_back({opcode, instruction});
      end
      if ((c - 1) % 4 == 0 && (c - 1) / 4 < fa.size())
        chk("fetch_addr", 32'(imem_addr), 32'(fa[(c - 1) / 4]));
    end
    start = 1'b0;

    chk("wr_count", 32'(obs_cyc.size()), 32'(exp_cyc.size()));
    for (int i = 0; i < obs_cyc.size() && i < exp_cyc.size(); i++) begin
      chk("wr_cycle", 32'(obs_cyc[i]), 32'(exp_cyc[i]));
      chk("wr_word", 32'(obs_w[i]), 32'(exp_w[i]));
    end
    if (halt_k >= 0) begin
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_addr", 32'(imem_addr), 32'(fa[halt_k]));
    end else begin
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
    end
    halted = (halt_k >= 0);
  endtask

  initial begin
    bit          h;
    int          wc;
    logic [15:0] w;
    rst       = 1'b1;
    start     = 1'b0;
    step      = 1'b0;
    step_mode = 1'b0;
    load4(16'h0, 16'h0, 16'h0, 16'h0);
    #12;
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_op", 32'(opcode), 32'd0);
    chk("rst_wr", 32'(reg_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ALU op then HALT
    load4(16'h1123, 16'hF000, 16'hF000, 16'hF000);
    run_prog(4, 0, h);

    // start mid-run is ignored; start in HALT restarts from address 0
    load4(16'h3A5C, 16'h4001, 16'hF000, 16'h0000);
    run_prog(6, 6, h);
    run_prog(6, 0, h);

    // NOP and wr=0 produce no strobe, PC still advances
    load4(16'h0456, 16'h2450, 16'hF000, 16'hF000);
    run_prog(4, 0, h);

    // PC wrap with continuous execution
    load4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_prog(5, 0, h);
    do_reset;

    // Single-step mode: one writeback per step pulse
    load4(16'h1123, 16'h2234, 16'h3345, 16'hF000);
    step_mode = 1'b1;
    wc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        start = 1'b0;
        step  = 1'b0;
        if (reg_write) wc++;
      end
      if (s < 3) begin
        chk("step_wr", 32'(wc), 32'(s + 1));
        chk("step_busy", 32'(busy), 32'd1);
        step = 1'b1;
      end else begin
        chk("step_total", 32'(wc), 32'd3);
        chk("step_done", 32'(done), 32'd1);
      end
    end
    step_mode = 1'b0;
    do_reset;

    // Reset asserted during WRITEBACK
    load4(16'h5127, 16'hF000, 16'hF000, 16'hF000);
    @(negedge clk);
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_wr", 32'(reg_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wr", 32'(reg_write), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ir", 32'({opcode, instruction}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_prog(4, 0, h);

    // Randomized programs
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        w = 16'($urandom);
        if ($urandom_range(0, 7) == 0) w[15:12] = 4'hF;
        mem[i] = w;
      end
      run_prog(8, int'($urandom_range(0, 3)), h);
      if (!h) do_reset;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, program-counter / instruction-memory address width.
REQ-002 SHALL have parameter: NOP_OP, 4'h0, opcode that performs no register write.
REQ-003 SHALL have parameter: HALT_OP, 4'hF, opcode that stops sequencing.
REQ-004 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  one-cycle pulse that begins execution from IDLE or HALT.
REQ-007 SHALL have port: step_mode  input  1  1 = pause after each writeback until step.
REQ-008 SHALL have port: step  input  1  one-cycle pulse that releases a paused instruction.
REQ-009 SHALL have port: imem_addr  output  ADDR_W  instruction-memory address (current PC).
REQ-010 SHALL have port: imem_data  input  16  instruction word {opcode[15:12], rd1[11:8], rd2[7:4], wr[3:0]}.
REQ-011 SHALL have port: instruction  output  12  register-field bits {rd1, rd2, wr} to the 4x16 register file.
REQ-012 SHALL have port: opcode  output  4  operation code to the ALU.
REQ-013 SHALL have port: reg_write  output  1  register-file write strobe.
REQ-014 SHALL have port: busy  output  1  high in FETCH, DECODE, EXECUTE, WRITEBACK and PAUSE.
REQ-015 SHALL have port: done  output  1  high (level) while in HALT.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, PAUSE and HALT.
REQ-017 IDLE->FETCH on start; HALT->FETCH on start, with PC cleared to 0 on that same edge.
REQ-018 FETCH: imem_addr = PC. Memory is synchronous with 1-cycle read latency. Always proceeds to DECODE.
REQ-019 DECODE: latches imem_data into the 16-bit instruction register (IR). Proceeds to EXECUTE.
REQ-020 instruction = IR[11:0] and opcode = IR[15:12], both driven from IR only and held stable until the next DECODE.
REQ-021 EXECUTE: if opcode == HALT_OP, go to HALT with PC unchanged; otherwise go to WRITEBACK.
REQ-022 WRITEBACK: reg_write = 1 for exactly this one cycle, only if opcode != NOP_OP and wr != 4'h0; else 0.
REQ-023 WRITEBACK: PC <= PC + 1 modulo 2^ADDR_W; PC wraps from all-ones to 0 with no flag.
REQ-024 WRITEBACK exit: if step_mode = 1, go to PAUSE; otherwise go to FETCH.
REQ-025 PAUSE: stays until step = 1, then goes to FETCH; step or start outside PAUSE, IDLE or HALT is ignored.
REQ-026 Per instruction: 4 cycles FETCH->WRITEBACK when step_mode = 0; HALT is detected 3 cycles after FETCH.
REQ-027 start while busy is ignored; PC is not altered.
REQ-028 step_mode is sampled only at WRITEBACK exit; changing it mid-instruction affects only the next boundary.
REQ-029 reg_write is 0 in every state other than WRITEBACK.

Reset
REQ-030 rst = 1 forces immediately (asynchronously): state = IDLE, PC = 0, IR = 16'h0000.
REQ-031 Under reset, outputs SHALL be: imem_addr = 0, instruction = 0, opcode = 0, reg_write = 0, busy = 0, done = 0.
REQ-032 Reset in any state, including mid-WRITEBACK, aborts the instruction with no write strobe and no PC increment.

Structure
REQ-033 A shared CPU package SHALL hold: state encoding, NOP_OP/HALT_OP opcode constants, and instruction field bit positions.
REQ-034 The package SHALL also hold the 16-bit instruction-word widths, for reuse by the register file and ALU.
REQ-035 No sub-module; PC, IR and the FSM SHALL reside in this module.

Verification
REQ-036 Program mem[0]=16'h1123, mem[1]=16'hF000; pulse start -> reg_write high exactly once, with instruction=12'h123, opcode=1, 4 cycles after start; then done=1 and imem_addr=1.
REQ-037 mem[0]=16'h0456 (NOP), mem[1]=16'h2450 (wr=0) -> reg_write never asserts; PC advances to 2.
REQ-038 step_mode=1 with three ALU ops -> FSM holds in PAUSE after each WRITEBACK; each step pulse yields exactly one more reg_write.
REQ-039 ADDR_W=2 with no HALT op -> imem_addr sequence 0,1,2,3,0; continuous execution with no stall.
REQ-040 rst asserted during WRITEBACK -> reg_write drops in the same cycle; PC=0, state IDLE; start re-runs from address 0.
REQ-041 start pulsed mid-run and again in HALT -> first is ignored; second restarts from imem_addr=0.
